// File: rtl/test_mem_arbiter.sv
// Two-port arbiter in front of the single test-memory port: round-robin with
// optional bounded lock, and routing of synchronous read data to the issuing port.
module test_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_lock,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_lock,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic [15:0]       stall_cnt
);

    // Handshake: a requester raises req with we/addr/wdata and holds them
    // stable; the access is taken in the cycle where gnt is high, and the
    // requester may present a new access in the following cycle.

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    logic              owner_q;
    logic              lock_q;
    logic [7:0]        hold_q;
    logic              owner_req;
    logic              other_req;
    logic              lock_win;
    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;
    logic              rd_push;
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_port;

    always_comb begin
        owner_req = owner_q ? p1_req : p0_req;
        other_req = owner_q ? p0_req : p1_req;
        lock_win  = lock_q & owner_req & (~other_req | (hold_q < HOLD_LIMIT));
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (lock_win) begin
            gnt0 = ~owner_q;
            gnt1 = owner_q;
        end else if (p0_req & p1_req) begin
            // A lock that hit its hold limit also lands here: the non-owner wins.
            gnt0 = owner_q;
            gnt1 = ~owner_q;
        end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
        end
    end

    assign gnt_any = gnt0 | gnt1;
    assign p0_gnt  = gnt0;
    assign p1_gnt  = gnt1;
    assign mem_en  = gnt_any;
    assign owner   = owner_q;
    assign rd_push = gnt_any & ~mem_we;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (gnt1) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= 1'b1;
            lock_q  <= 1'b0;
            hold_q  <= '0;
        end else if (gnt_any) begin
            owner_q <= gnt1;
            lock_q  <= gnt1 ? p1_lock : p0_lock;
            // Saturate at the limit so a long uncontested lock cannot wrap
            // and starve a port that arrives later.
            if (lock_q && (gnt1 == owner_q))
                hold_q <= (hold_q < HOLD_LIMIT) ? hold_q + 8'd1 : hold_q;
            else
                hold_q <= 8'd1;
        end else if (lock_q && !owner_req) begin
            lock_q <= 1'b0;
            hold_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (((p0_req & ~gnt0) | (p1_req & ~gnt1)) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Read tags travel alongside the memory latency; the last stage lines up
    // with mem_rdata for the read that was issued RD_LAT cycles earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld  <= '0;
            pipe_port <= '0;
        end else begin
            pipe_vld[0]  <= rd_push;
            pipe_port[0] <= gnt1;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_port[i] <= pipe_port[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= pipe_vld[RD_LAT-1] & ~pipe_port[RD_LAT-1];
            p1_rvalid <= pipe_vld[RD_LAT-1] & pipe_port[RD_LAT-1];
            if (pipe_vld[RD_LAT-1] && !pipe_port[RD_LAT-1])
                p0_rdata <= mem_rdata;
            if (pipe_vld[RD_LAT-1] && pipe_port[RD_LAT-1])
                p1_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_test_mem_arbiter.sv
// Directed bench for test_mem_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for lock fairness, reset mid-read and saturation.
module tb_test_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req, p0_lock, p0_we;
    logic [31:0] p0_addr, p0_wdata;
    logic        p0_gnt, p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p1_req, p1_lock, p1_we;
    logic [31:0] p1_addr, p1_wdata;
    logic        p1_gnt, p1_rvalid;
    logic [31:0] p1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        owner;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int dbl_gnt = 0;

    always #5 clk = ~clk;

    test_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .MAX_HOLD(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .stall_cnt(stall_cnt)
    );

    // Memory model, latency 1: unwritten words read back as address*3.
    logic [31:0] mem_arr [0:63];
    logic [63:0] written;
    always @(posedge clk) begin
        if (!rst_n) begin
            written <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                mem_arr[mem_addr[5:0]] <= mem_wdata;
                written[mem_addr[5:0]] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr[5:0]] ? mem_arr[mem_addr[5:0]]
                                                    : 32'(mem_addr[5:0]) * 32'd3;
            end
        end
    end

    always @(negedge clk) if (p0_gnt && p1_gnt) dbl_gnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        p0_req = 1'b0; p0_lock = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_lock = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // c = {req, lock, we}; e = {p0_gnt, p1_gnt, mem_we, p0_rvalid, p1_rvalid}
    typedef struct {
        logic        rst;
        logic [2:0]  c0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [2:0]  c1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [4:0]  e;
        logic [31:0] rd;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    initial begin
        int n1;
        int c;
        int rv_seen;
        logic seen0;

        idle_inputs();
        // single port write then read, data 2 cycles after the read grant
        vecs[0]  = '{1'b1, 3'b101, 32'h10, 32'hDEADBEEF, 3'b000, 32'h0, 32'h0, 5'b10100, 32'h0};
        vecs[1]  = '{1'b0, 3'b100, 32'h10, 32'h0, 3'b000, 32'h0, 32'h0, 5'b10000, 32'h0};
        vecs[2]  = '{1'b0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 5'b00000, 32'h0};
        vecs[3]  = '{1'b0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 5'b00010, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 5'b00000, 32'h0};
        // interleaved reads return in order to the issuing port
        vecs[5]  = '{1'b0, 3'b100, 32'h4, 32'h0, 3'b000, 32'h0, 32'h0, 5'b10000, 32'h0};
        vecs[6]  = '{1'b0, 3'b000, 32'h0, 32'h0, 3'b100, 32'h8, 32'h0, 5'b01000, 32'h0};
        vecs[7]  = '{1'b0, 3'b100, 32'hC, 32'h0, 3'b000, 32'h0, 32'h0, 5'b10010, 32'hC};
        vecs[8]  = '{1'b0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 5'b00001, 32'h18};
        vecs[9]  = '{1'b0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 5'b00010, 32'h24};
        vecs[10] = '{1'b0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 5'b00000, 32'h0};
        // both requesting from reset: strict alternation starting with port 0
        vecs[11] = '{1'b1, 3'b100, 32'h20, 32'h0, 3'b100, 32'h24, 32'h0, 5'b10000, 32'h0};
        vecs[12] = '{1'b0, 3'b100, 32'h20, 32'h0, 3'b100, 32'h24, 32'h0, 5'b01000, 32'h0};
        vecs[13] = '{1'b0, 3'b100, 32'h20, 32'h0, 3'b100, 32'h24, 32'h0, 5'b10010, 32'h60};
        vecs[14] = '{1'b0, 3'b100, 32'h20, 32'h0, 3'b100, 32'h24, 32'h0, 5'b01001, 32'h6C};
        vecs[15] = '{1'b0, 3'b100, 32'h20, 32'h0, 3'b100, 32'h24, 32'h0, 5'b10010, 32'h60};
        vecs[16] = '{1'b0, 3'b100, 32'h20, 32'h0, 3'b100, 32'h24, 32'h0, 5'b01001, 32'h6C};
        vecs[17] = '{1'b0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 5'b00010, 32'h60};
        vecs[18] = '{1'b0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 5'b00001, 32'h6C};
        // port 0 lock keeps ownership, then releases when port 0 stops requesting
        vecs[19] = '{1'b1, 3'b110, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 5'b10000, 32'h0};
        vecs[20] = '{1'b0, 3'b110, 32'h0, 32'h0, 3'b100, 32'h8, 32'h0, 5'b10000, 32'h0};
        vecs[21] = '{1'b0, 3'b000, 32'h0, 32'h0, 3'b100, 32'h8, 32'h0, 5'b01010, 32'h0};
        vecs[22] = '{1'b0, 3'b100, 32'h4, 32'h0, 3'b100, 32'h8, 32'h0, 5'b10010, 32'h0};
        vecs[23] = '{1'b0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 5'b00001, 32'h18};
        vecs[24] = '{1'b0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 5'b00010, 32'hC};

        // reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_p0_gnt", 32'(p0_gnt), 32'h0);
        check("rst_p1_gnt", 32'(p1_gnt), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rvalid", {30'h0, p0_rvalid, p1_rvalid}, 32'h0);
        check("rst_rdata", p0_rdata | p1_rdata, 32'h0);
        check("rst_owner", 32'(owner), 32'h1);
        check("rst_stall", 32'(stall_cnt), 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) do_reset();
            {p0_req, p0_lock, p0_we} = vecs[i].c0;
            p0_addr = vecs[i].a0; p0_wdata = vecs[i].d0;
            {p1_req, p1_lock, p1_we} = vecs[i].c1;
            p1_addr = vecs[i].a1; p1_wdata = vecs[i].d1;
            @(negedge clk);
            check($sformatf("v%0d_gnt", i), {30'h0, p0_gnt, p1_gnt}, {30'h0, vecs[i].e[4:3]});
            check($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e[4] | vecs[i].e[3]));
            check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e[2]));
            check($sformatf("v%0d_rvalid", i), {30'h0, p0_rvalid, p1_rvalid}, {30'h0, vecs[i].e[1:0]});
            if (vecs[i].e[4]) check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].a0);
            if (vecs[i].e[3]) check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].a1);
            if (vecs[i].e[1]) check($sformatf("v%0d_p0_rdata", i), p0_rdata, vecs[i].rd);
            if (vecs[i].e[0]) check($sformatf("v%0d_p1_rdata", i), p1_rdata, vecs[i].rd);
            @(posedge clk); #1;
            if (i == 18) begin
                @(negedge clk);
                check("alt_stall_cnt", 32'(stall_cnt), 32'd6);
                @(posedge clk); #1;
            end
        end

        // port 1 locked bursts against a waiting port 0: 16 grants, then port 0
        do_reset();
        p1_req = 1'b1; p1_lock = 1'b1; p1_we = 1'b0; p1_addr = 32'h8;
        n1 = 0; c = 0; seen0 = 1'b0;
        while (!seen0 && c < 40) begin
            @(negedge clk);
            if (p1_gnt) n1++;
            if (p0_gnt) seen0 = 1'b1;
            @(posedge clk); #1;
            p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h4;
            c++;
        end
        check("lock_p0_granted", 32'(seen0), 32'h1);
        check("lock_p1_grants", n1, 32'd16);
        @(negedge clk);
        check("lock_cleared_rr", {30'h0, p0_gnt, p1_gnt}, 32'h1);
        @(posedge clk); #1;

        // reset pulsed while a port 1 read is in flight
        do_reset();
        p0_req = 1'b1; p0_addr = 32'h4;
        p1_req = 1'b1; p1_addr = 32'h8;
        @(negedge clk);
        check("mid_first_gnt", {30'h0, p0_gnt, p1_gnt}, 32'h2);
        @(posedge clk); #1;
        p0_req = 1'b0;
        @(negedge clk);
        check("mid_p1_gnt", 32'(p1_gnt), 32'h1);
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rv_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (p0_rvalid || p1_rvalid) rv_seen++;
        end
        check("mid_no_rvalid", rv_seen, 32'd0);
        check("mid_owner", 32'(owner), 32'h1);
        check("mid_stall", 32'(stall_cnt), 32'h0);
        check("mid_rdata", p1_rdata, 32'h0);
        @(posedge clk); #1;

        // stall counter saturation
        do_reset();
        p0_req = 1'b1; p0_addr = 32'h4;
        p1_req = 1'b1; p1_addr = 32'h8;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("stall_below_sat", 32'(stall_cnt), 32'hFFFE);
        repeat (4500) @(posedge clk);
        @(negedge clk);
        check("stall_saturated", 32'(stall_cnt), 32'hFFFF);
        idle_inputs();

        check("single_gnt_per_cycle", dbl_gnt, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/test_mem_arbiter.md
Name: test_mem_arbiter

Overview:
- Shares the single test-memory port between two requesters: port 0 is the UART host controller (load vectors, read results), port 1 is the test sequencer.
- Round-robin arbitration, optional lock for back-to-back bursts, and a fairness limit on lock duration.
- Routes synchronous read data back to the port that issued the read.
- Sits between uart_controller / fpga_test_wrapper and the test-memory BRAM.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles (1..4).
- MAX_HOLD, 16, maximum consecutive grants to a locked port while the other port is requesting (2..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- p0_req  in  1  port 0 access request
- p0_lock  in  1  port 0 requests to keep ownership after this access
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  ADDR_W  port 0 address
- p0_wdata  in  DATA_W  port 0 write data
- p0_gnt  out  1  port 0 access accepted this cycle
- p0_rvalid  out  1  port 0 read data valid
- p0_rdata  out  DATA_W  port 0 read data
- p1_req, p1_lock, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  same as port 0, for port 1
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after a read strobe
- owner  out  1  port that was granted most recently
- stall_cnt  out  16  saturating count of cycles in which any request was not granted

Behaviour:
- Reset: all gnt, rvalid, mem_en and mem_we are 0. rdata, mem_addr and mem_wdata are 0. owner = 1, so port 0 wins the first tie. Hold count is 0, lock is inactive, stall_cnt is 0, and the read pipeline is cleared.
- Clocking: everything is clocked on the rising edge of clk; reset is asynchronous on the falling edge of rst_n.
- Grant logic: pX_gnt is combinational from the requests and the registered state.
  - At most one gnt per cycle.
  - A granted request is accepted in that same cycle; the requester holds req/we/addr/wdata stable until it sees gnt.
- Memory outputs (mem_en, mem_we, mem_addr, mem_wdata) are combinational muxes of the granted port's signals.
  - mem_en = p0_gnt | p1_gnt.
  - When no port is granted, mem_en = 0 and mem_we = 0.
- Arbitration, evaluated each cycle:
  - Lock active for port L, and L requesting, and (other port idle or hold < MAX_HOLD): grant L.
  - Lock active, other port requesting, and hold == MAX_HOLD: grant the other port and clear the lock.
  - Lock active and L not requesting: the lock is released and normal arbitration applies in the same cycle.
  - No lock, one requester: grant it.
  - No lock, both requesting: grant the port != owner.
- State update on a grant to port G:
  - owner <= G.
  - Lock active with a new lock <= pG_lock.
  - hold <= hold + 1 if G == previous owner and the lock was active; otherwise hold <= 1.
  - With no grant, hold keeps its value unless the lock is released, in which case hold <= 0.
- Read return:
  - For each read grant (gnt & ~we), push {valid, port} into an RD_LAT-deep shift register.
  - At the output stage, pX_rvalid = 1 for one cycle and pX_rdata <= mem_rdata, both registered. Read data therefore appears RD_LAT+1 cycles after gnt.
  - Back-to-back reads from mixed ports return in issue order, one per cycle.
  - Writes produce no rvalid.
  - pX_rdata holds its last value when rvalid = 0.
- stall_cnt increments when (p0_req & ~p0_gnt) | (p1_req & ~p1_gnt), and saturates at 0xFFFF.
- Reset asserted mid-operation:
  - In-flight reads are discarded and no rvalid follows after reset is released.
  - The lock and hold count clear.
- A requester deasserting req without being granted is legal; no state change results.

Test Plan:
- Port 0 only, write 0xDEADBEEF to address 0x10, then read 0x10: p0_gnt in both request cycles, mem_we = 1 then 0, p0_rvalid exactly 2 cycles after the read gnt (RD_LAT = 1) with p0_rdata = 0xDEADBEEF, and p1_rvalid never set.
- Both ports hold req high for 6 cycles, no lock, starting from reset: grants alternate 0,1,0,1,0,1, and stall_cnt = 6.
- Port 1 locked continuous reads while port 0 requests throughout, MAX_HOLD = 16: port 1 receives exactly 16 grants, then port 0 is granted, and the lock clears.
- Interleaved reads P0 @0x4, P1 @0x8, P0 @0xC on consecutive grant cycles, memory contents = address*3: p0_rdata = 0xC, p1_rdata = 0x18, p0_rdata = 0x24, on consecutive cycles to the correct ports.
- A port 1 read is granted, then rst_n is pulsed low on the next cycle: no p1_rvalid after release, owner = 1, stall_cnt = 0.
- Hold both requests high for more than 70000 cycles: stall_cnt saturates at 0xFFFF.
